// File: rtl/sync_fifo_reader.sv
// Read-side controller for sync_fifo: pops under a credit limit, tracks each pop through the
// FIFO read latency, and lands returned words in a skid buffer drained by a valid/ready stream.
module sync_fifo_reader #(
    parameter int DWIDTH            = 16,
    parameter int DEPTH             = 16,
    parameter int AWIDTH            = $clog2(DEPTH),
    parameter int COMMON_BRAM_DELAY = 2,
    parameter int SKID_DEPTH        = COMMON_BRAM_DELAY + 2
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                enable,
    output logic                                fifo_pop,
    input  logic [DWIDTH-1:0]                   fifo_out,
    input  logic                                fifo_empty,
    input  logic [AWIDTH:0]                     fifo_num,
    output logic                                m_valid,
    output logic [DWIDTH-1:0]                   m_data,
    input  logic                                m_ready,
    output logic [$clog2(COMMON_BRAM_DELAY+1):0] inflight_cnt,
    output logic [$clog2(SKID_DEPTH):0]         skid_cnt,
    output logic                                busy
);

    localparam int D  = COMMON_BRAM_DELAY;
    localparam int IW = $clog2(D + 1) + 1;
    localparam int SW = $clog2(SKID_DEPTH) + 1;
    localparam int PW = $clog2(SKID_DEPTH);
    localparam int CW = ((IW > SW) ? IW : SW) + 1;

    logic              w_capture;
    logic              w_handshake;
    logic [IW-1:0]     w_inflight;
    logic [CW-1:0]     w_committed;
    logic [SW-1:0]     r_cnt;
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [DWIDTH-1:0] r_mem [SKID_DEPTH];
    logic              w_unused;

    // fifo_num is exported by the FIFO for debug only and takes no part in control.
    assign w_unused = ^fifo_num;

    generate
        if (D == 0) begin : g_fall_through
            assign w_capture  = fifo_pop;
            assign w_inflight = '0;
        end else begin : g_latency_pipe
            logic [D-1:0] r_vld_sr;

            always_ff @(posedge clk or negedge reset_n) begin
                // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
                if (!reset_n) r_vld_sr <= '0;
                else          r_vld_sr <= (r_vld_sr << 1) | D'(fifo_pop);
            end

            assign w_capture = r_vld_sr[D-1];

            always_comb begin
                // NOTE: default assignment first so the combinational block can never infer a latch.
                w_inflight = '0;
                for (int i = 0; i < D; i++) w_inflight = w_inflight + IW'(r_vld_sr[i]);
            end
        end
    endgenerate

    // Credit check ignores a same-cycle handshake on purpose: conservative but never over-commits.
    assign w_committed = CW'(w_inflight) + CW'(r_cnt);
    assign fifo_pop    = reset_n & enable & ~fifo_empty & (w_committed < CW'(SKID_DEPTH));

    assign m_valid      = (r_cnt != '0);
    assign w_handshake  = m_valid & m_ready;
    assign m_data       = m_valid ? r_mem[r_rptr] : '0;
    assign inflight_cnt = w_inflight;
    assign skid_cnt     = r_cnt;
    assign busy         = (w_inflight != '0) | m_valid;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_capture)   r_wptr <= next_ptr(r_wptr);
            if (w_handshake) r_rptr <= next_ptr(r_rptr);
            case ({w_capture, w_handshake})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // NOTE: storage is not reset; entries are only visible through m_data while skid_cnt says they are live.
    always_ff @(posedge clk) begin
        if (w_capture) r_mem[r_wptr] <= fifo_out;
    end

endmodule

// File: tb/tb_sync_fifo_reader.sv
// Bench for sync_fifo_reader: a D=2/SKID=4 instance and a D=0/SKID=2 instance, each fed by a
// behavioural FIFO model, with a scoreboard of pushed words compared against the output stream.
module tb_sync_fifo_reader;

    localparam int DW = 8;
    localparam int DEPTH = 16;
    localparam int AW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic reset_n, enable, m_ready, enable_z, m_ready_z;
    logic push = 1'b0, push_z = 1'b0;
    logic [DW-1:0] push_data = '0, push_data_z = '0;

    logic          fifo_pop, m_valid, busy;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_out = '0;
    logic [AW:0]   fifo_num = '0;
    logic [DW-1:0] m_data;
    logic [2:0]    inflight_cnt, skid_cnt;

    logic          fifo_pop_z, m_valid_z, busy_z;
    logic          fifo_empty_z = 1'b1;
    logic [DW-1:0] fifo_out_z = '0;
    logic [AW:0]   fifo_num_z = '0;
    logic [DW-1:0] m_data_z;
    logic [0:0]    inflight_cnt_z;
    logic [1:0]    skid_cnt_z;

    sync_fifo_reader #(.DWIDTH(DW), .DEPTH(DEPTH), .AWIDTH(AW), .COMMON_BRAM_DELAY(2), .SKID_DEPTH(4)) u_dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .fifo_pop(fifo_pop), .fifo_out(fifo_out),
        .fifo_empty(fifo_empty), .fifo_num(fifo_num), .m_valid(m_valid), .m_data(m_data),
        .m_ready(m_ready), .inflight_cnt(inflight_cnt), .skid_cnt(skid_cnt), .busy(busy)
    );

    sync_fifo_reader #(.DWIDTH(DW), .DEPTH(DEPTH), .AWIDTH(AW), .COMMON_BRAM_DELAY(0), .SKID_DEPTH(2)) u_dut_z (
        .clk(clk), .reset_n(reset_n), .enable(enable_z), .fifo_pop(fifo_pop_z), .fifo_out(fifo_out_z),
        .fifo_empty(fifo_empty_z), .fifo_num(fifo_num_z), .m_valid(m_valid_z), .m_data(m_data_z),
        .m_ready(m_ready_z), .inflight_cnt(inflight_cnt_z), .skid_cnt(skid_cnt_z), .busy(busy_z)
    );

    // FIFO models: registered push, synchronous reset while reset_n is low.
    logic [DW-1:0] q_a[$];
    logic [DW-1:0] q_z[$];
    logic [DW-1:0] exp_a[$];
    logic [DW-1:0] exp_z[$];
    logic [DW-1:0] pipe_a = '0;
    int delivered_a = 0;
    int delivered_z = 0;

    always @(posedge clk) begin
        logic [DW-1:0] popped;
        popped = '0;
        if (!reset_n) begin
            q_a.delete();
            pipe_a = '0;
            fifo_out <= '0;
        end else begin
            if (fifo_pop && q_a.size() != 0) popped = q_a.pop_front();
            if (push) q_a.push_back(push_data);
            fifo_out <= pipe_a;
            pipe_a = popped;
        end
        fifo_empty <= (q_a.size() == 0);
        fifo_num   <= (AW+1)'(q_a.size());
    end

    always @(posedge clk) begin
        if (!reset_n) q_z.delete();
        else begin
            if (fifo_pop_z && q_z.size() != 0) void'(q_z.pop_front());
            if (push_z) q_z.push_back(push_data_z);
        end
        fifo_empty_z <= (q_z.size() == 0);
        fifo_num_z   <= (AW+1)'(q_z.size());
        fifo_out_z   <= (q_z.size() != 0) ? q_z[0] : '0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard monitors: a handshake seen at the falling edge completes at the next rising edge.
    always @(negedge clk) begin
        if (reset_n && m_valid && m_ready) begin
            checks++;
            assert (exp_a.size() != 0) else begin
                errors++;
                $error("FAIL sb_a_unexpected: observed=%0h expected=none", m_data);
            end
            if (exp_a.size() != 0) check("sb_a_data", 32'(m_data), 32'(exp_a.pop_front()));
            delivered_a++;
        end
    end

    always @(negedge clk) begin
        if (reset_n && m_valid_z && m_ready_z) begin
            checks++;
            assert (exp_z.size() != 0) else begin
                errors++;
                $error("FAIL sb_z_unexpected: observed=%0h expected=none", m_data_z);
            end
            if (exp_z.size() != 0) check("sb_z_data", 32'(m_data_z), 32'(exp_z.pop_front()));
            delivered_z++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_a(input logic [DW-1:0] d);
        push = 1'b1;
        push_data = d;
        exp_a.push_back(d);
        step(1);
        push = 1'b0;
    endtask

    task automatic push_zw(input logic [DW-1:0] d);
        push_z = 1'b1;
        push_data_z = d;
        exp_z.push_back(d);
        step(1);
        push_z = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_inf[8]  = '{0, 1, 2, 2, 1, 0, 0, 0};
        int exp_skid[8] = '{0, 0, 0, 1, 1, 1, 0, 0};
        int exp_pop4[6] = '{0, 1, 0, 0, 0, 0};
        int exp_vld4[6] = '{0, 0, 0, 0, 1, 0};
        logic          held;
        logic [DW-1:0] held_data;
        int            base;

        reset_n = 1'b0; enable = 1'b0; m_ready = 1'b1; enable_z = 1'b0; m_ready_z = 1'b0;
        step(2);
        @(negedge clk);
        check("rst_pop", 32'(fifo_pop), 0);
        check("rst_valid", 32'(m_valid), 0);
        check("rst_data", 32'(m_data), 0);
        check("rst_inflight", 32'(inflight_cnt), 0);
        check("rst_skid", 32'(skid_cnt), 0);
        check("rst_busy", 32'(busy), 0);
        step(1);
        reset_n = 1'b1;

        // Three preloaded words, consumer always ready.
        push_a(8'h11); push_a(8'h22); push_a(8'h33);
        enable = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check($sformatf("t1_pop_c%0d", c), 32'(fifo_pop), (c < 3) ? 1 : 0);
            check($sformatf("t1_valid_c%0d", c), 32'(m_valid), (c >= 3 && c <= 5) ? 1 : 0);
            check($sformatf("t1_busy_c%0d", c), 32'(busy), (c >= 1 && c <= 5) ? 1 : 0);
            check($sformatf("t1_inflight_c%0d", c), 32'(inflight_cnt), 32'(exp_inf[c]));
            check($sformatf("t1_skid_c%0d", c), 32'(skid_cnt), 32'(exp_skid[c]));
            step(1);
        end
        check("t1_delivered", 32'(delivered_a), 3);

        // Ten words under full backpressure, then release.
        enable = 1'b0; m_ready = 1'b0;
        for (int i = 0; i < 10; i++) push_a(8'(8'h40 + i));
        enable = 1'b1;
        step(8);
        @(negedge clk);
        check("t2_pop_stopped", 32'(fifo_pop), 0);
        check("t2_skid_full", 32'(skid_cnt), 4);
        check("t2_inflight", 32'(inflight_cnt), 0);
        check("t2_fifo_num", 32'(fifo_num), 6);
        check("t2_head", 32'(m_data), 32'h40);
        step(1);
        m_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("t2_stream_c%0d", c), 32'(m_valid), 1);
            step(1);
        end
        @(negedge clk);
        check("t2_busy_clear", 32'(busy), 0);
        check("t2_delivered", 32'(delivered_a), 13);
        step(1);

        // Fall-through instance with toggling consumer.
        push_zw(8'h51); push_zw(8'h52); push_zw(8'h53); push_zw(8'h54);
        enable_z = 1'b1;
        held = 1'b0;
        held_data = '0;
        for (int c = 0; c < 12; c++) begin
            m_ready_z = (c % 2 == 0);
            @(negedge clk);
            if (held) begin
                check($sformatf("t3_stable_valid_c%0d", c), 32'(m_valid_z), 1);
                check($sformatf("t3_stable_data_c%0d", c), 32'(m_data_z), 32'(held_data));
            end
            check($sformatf("t3_inflight_c%0d", c), 32'(inflight_cnt_z), 0);
            held = m_valid_z & ~m_ready_z;
            held_data = m_data_z;
            step(1);
        end
        @(negedge clk);
        check("t3_delivered", 32'(delivered_z), 4);
        check("t3_busy_clear", 32'(busy_z), 0);
        step(1);

        // Empty FIFO, then a single push.
        m_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c == 0) begin
                push = 1'b1;
                push_data = 8'hAB;
                exp_a.push_back(8'hAB);
            end
            @(negedge clk);
            check($sformatf("t4_pop_c%0d", c), 32'(fifo_pop), 32'(exp_pop4[c]));
            check($sformatf("t4_valid_c%0d", c), 32'(m_valid), 32'(exp_vld4[c]));
            if (c == 4) check("t4_data", 32'(m_data), 32'hAB);
            step(1);
            push = 1'b0;
        end
        check("t4_delivered", 32'(delivered_a), 14);

        // Drop enable with two words in flight.
        enable = 1'b0;
        for (int i = 0; i < 5; i++) push_a(8'(8'h61 + i));
        enable = 1'b1;
        step(2);
        enable = 1'b0;
        @(negedge clk);
        check("t5_pop_off", 32'(fifo_pop), 0);
        check("t5_inflight", 32'(inflight_cnt), 2);
        check("t5_busy", 32'(busy), 1);
        step(3);
        @(negedge clk);
        check("t5_busy_clear", 32'(busy), 0);
        check("t5_delivered", 32'(delivered_a), 16);
        check("t5_fifo_num", 32'(fifo_num), 3);
        step(1);

        // Asynchronous reset mid-operation with words buffered and in flight.
        push_a(8'h66); push_a(8'h67);
        m_ready = 1'b0;
        enable = 1'b1;
        step(4);
        @(negedge clk);
        check("t6_pre_skid", 32'(skid_cnt), 2);
        check("t6_pre_inflight", 32'(inflight_cnt), 2);
        #2;
        reset_n = 1'b0;
        exp_a.delete();
        #1;
        check("t6_rst_pop", 32'(fifo_pop), 0);
        check("t6_rst_valid", 32'(m_valid), 0);
        check("t6_rst_data", 32'(m_data), 0);
        check("t6_rst_inflight", 32'(inflight_cnt), 0);
        check("t6_rst_skid", 32'(skid_cnt), 0);
        check("t6_rst_busy", 32'(busy), 0);
        step(1);
        reset_n = 1'b1;
        m_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("t6_no_stale_c%0d", c), 32'(m_valid), 0);
            step(1);
        end
        base = delivered_a;
        push_a(8'hCD);
        step(5);
        @(negedge clk);
        check("t6_fresh_delivered", 32'(delivered_a - base), 1);
        check("t6_sb_drained", 32'(exp_a.size()), 0);
        check("t6_busy_clear", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
